// File: rtl/fpu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fpu_op_sequencer
// Purpose  : Multicycle READ -> EXEC -> WB sequencer between FP decode,
//            FP register file and a variable-latency FP execute unit.
// Revision : 1.0  initial release
// ============================================================================
module fpu_op_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [1:0]  issue_op,
    input  logic        issue_single,
    input  logic [3:0]  issue_rn,
    input  logic [3:0]  issue_rm,
    input  logic [3:0]  issue_rd,
    input  logic        issue_an,
    input  logic        issue_am,
    input  logic        issue_ad,
    output logic [3:0]  rf_ra1,
    output logic [3:0]  rf_ra2,
    output logic [3:0]  rf_wa3,
    output logic        rf_a1,
    output logic        rf_a2,
    output logic        rf_a3,
    output logic        rf_single,
    output logic        rf_we3,
    output logic [31:0] rf_wd3,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    output logic        fpu_start,
    output logic [1:0]  fpu_op,
    output logic        fpu_single,
    output logic [31:0] fpu_srca,
    output logic [31:0] fpu_srcb,
    input  logic        fpu_done,
    input  logic [31:0] fpu_result,
    input  logic [3:0]  fpu_nzcv,
    output logic        flags_we,
    output logic [3:0]  flags_out,
    output logic        op_done,
    output logic        timeout_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam logic [1:0]    OP_CMP   = 2'b11;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic          single_q, single_d;
    logic [3:0]    rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
    logic          an_q, an_d, am_q, am_d, ad_q, ad_d;
    logic [31:0]   srca_q, srca_d, srcb_q, srcb_d;
    logic [31:0]   result_q, result_d;
    logic [3:0]    nzcv_q, nzcv_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            single_q  <= 1'b0;
            rn_q      <= '0;
            rm_q      <= '0;
            rd_q      <= '0;
            an_q      <= 1'b0;
            am_q      <= 1'b0;
            ad_q      <= 1'b0;
            srca_q    <= '0;
            srcb_q    <= '0;
            result_q  <= '0;
            nzcv_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            single_q  <= single_d;
            rn_q      <= rn_d;
            rm_q      <= rm_d;
            rd_q      <= rd_d;
            an_q      <= an_d;
            am_q      <= am_d;
            ad_q      <= ad_d;
            srca_q    <= srca_d;
            srcb_q    <= srcb_d;
            result_q  <= result_d;
            nzcv_q    <= nzcv_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        single_d  = single_q;
        rn_d      = rn_q;
        rm_d      = rm_q;
        rd_d      = rd_q;
        an_d      = an_q;
        am_d      = am_q;
        ad_d      = ad_q;
        srca_d    = srca_q;
        srcb_d    = srcb_q;
        result_d  = result_q;
        nzcv_d    = nzcv_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (issue_valid) begin
                    op_d     = issue_op;
                    single_d = issue_single;
                    rn_d     = issue_rn;
                    rm_d     = issue_rm;
                    rd_d     = issue_rd;
                    an_d     = issue_an;
                    am_d     = issue_am;
                    ad_d     = issue_ad;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                srca_d  = rf_rd1;
                srcb_d  = rf_rd2;
                cnt_d   = '0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                cnt_d = cnt_q + 1'b1;
                // done in the launch cycle belongs to no operation of ours; done beats timeout
                if (fpu_done && (cnt_q != '0)) begin
                    result_d = fpu_result;
                    nzcv_d   = fpu_nzcv;
                    state_d  = S_WB;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign issue_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign rf_ra1      = rn_q;
    assign rf_ra2      = rm_q;
    assign rf_wa3      = rd_q;
    assign rf_a1       = an_q;
    assign rf_a2       = am_q;
    assign rf_a3       = ad_q;
    assign rf_single   = single_q;
    assign rf_we3      = (state_q == S_WB) && (op_q != OP_CMP);
    assign rf_wd3      = single_q ? result_q : {16'b0, result_q[15:0]};
    assign fpu_start   = (state_q == S_EXEC) && (cnt_q == '0);
    assign fpu_op      = op_q;
    assign fpu_single  = single_q;
    assign fpu_srca    = srca_q;
    assign fpu_srcb    = srcb_q;
    assign flags_we    = (state_q == S_WB);
    assign flags_out   = nzcv_q;
    assign op_done     = (state_q == S_WB);
    assign timeout_err = timeout_q;

endmodule
`default_nettype wire
